// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_pkg
// Purpose  : Shared constants and types for the 8:1 round-robin collector.
//            The sel_t type matches the 1:8 demux select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter_8
// Purpose  : Combinational eight-way round-robin search. The search starts at
//            ptr, goes upward and wraps from 7 to 0. The first active request
//            found wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output sel_t            gnt_idx,
  output logic            any_gnt
);

  sel_t cand;

  // Scan the offsets from farthest to nearest so the nearest request wins.
  // gnt_idx keeps the value of ptr when no request is active.
  always_comb begin
    gnt_idx = ptr;
    any_gnt = 1'b0;
    cand    = ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        gnt_idx = cand;
        any_gnt = 1'b1;
      end
    end
  end

endmodule : rr_arbiter_8

`default_nettype wire

// File: rtl/mux_8_1_rr.sv
//------------------------------------------------------------------------------
// Module   : mux_8_1_rr
// Purpose  : Eight-channel round-robin stream collector. It merges eight
//            valid/ready inputs onto one registered output and tags each word
//            with its source channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_8_1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output sel_t                  out_sel,
  input  logic                  out_ready
);

  sel_t ptr;
  sel_t gnt_idx;
  logic any_gnt;
  logic load_en;
  logic xfer;

  rr_arbiter_8 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // The output register can take a new word when it is empty or is being
  // drained this cycle. No grant is issued while reset is held.
  assign load_en = ~out_valid | out_ready;
  assign xfer    = rst_n & load_en & any_gnt;

  // One-hot accept to the winning channel only.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (gnt_idx == sel_t'(i));
    end
  end

  // Output register and priority pointer. A transfer loads the winner and
  // moves the winner to lowest priority. A drain with no new word only clears
  // out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + sel_t'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : mux_8_1_rr

`default_nettype wire

// File: doc/mux_8_1_rr.md
# mux_8_1_rr

Eight-channel round-robin stream collector: merges eight valid/ready input channels onto one registered output stream and tags each word with its source channel. It is the gathering counterpart of the 1:8 demux: traffic fanned out by the demux on a 3-bit select is recombined here, with `out_sel` reproducing the select value. It sits at the join point of per-channel datapaths ahead of a single shared consumer.

## Interface
- `WIDTH`, 8, data word width per channel.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  8  per-channel valid; bit i = channel i.
- `in_data`  in  8*WIDTH  channel i word at `[i*WIDTH +: WIDTH]`.
- `in_ready`  out  8  per-channel accept; at most one bit high per cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word.
- `out_sel`  out  3  source channel index of `out_data` (binary, 0–7).
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.

## Operation
- **Load enable:** `load_en = ~out_valid | out_ready`.
- **Arbitration:** round-robin over channels whose `in_valid` is high. The search starts at `ptr`, ascending and wrapping 7→0. The first valid channel found wins.
- **Grant:** `in_ready[g] = load_en & any_valid`. All other `in_ready` bits are 0. A transfer on channel i occurs when `in_valid[i] & in_ready[i]`.
- **On a transfer from g:**
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= g+1` (mod 8). The winner drops to lowest priority.
- **No transfer, `out_ready` high:** `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- **No transfer, `load_en` low:** all output state holds (stall).
- **No valid inputs:** `ptr` is unchanged.
- **Combinational paths:** `in_ready` depends combinationally on `in_valid` and `out_ready`. Upstream must not make `in_valid` depend on `in_ready`.
- **Data stability:** once a word is presented, the output register is stable while `out_valid & ~out_ready`.

## Timing
- **Reset** (`rst_n` low at a `clk` edge): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
- `in_ready` is forced to 0 during any cycle with `rst_n` low.
- Reset mid-transfer discards the held word. No transfer completes on the reset edge.
- **Latency:** 1 cycle from input handshake to `out_valid`.
- **Throughput:** 1 word/cycle when `out_ready` stays high.
- **Simultaneous events:** when `out_ready` is high and a new input is granted in the same cycle, the held word is consumed and the new word loaded on the same edge, with no bubble.
- **Fairness:** with all eight channels continuously valid and `out_ready=1`, `out_sel` sequence after reset is 0,1,2,…,7,0,…
- **Starvation bound:** a continuously valid channel waits at most 7 transfers.

## Structure
- Package `mux_pkg`:
  - `N_CH = 8`, `SEL_W = 3`.
  - Typedef `sel_t` (logic [SEL_W-1:0]), shared with the demux select.
- Sub-module `rr_arbiter_8`:
  - Inputs: `req[7:0]`, `ptr`.
  - Outputs: `gnt_idx`, `any_gnt`.
  - Purely combinational.
  - The `ptr` register and datapath stay in the top.

## Test plan
1. **Reset:** hold `rst_n=0` for 3 cycles with all `in_valid=1` → `out_valid=0`, `in_ready=0`, `out_sel=0`. First grant after release is channel 0.
2. **Full load:** all channels valid, data = 8'hA0+i, `out_ready=1` → `out_data` A0,A1,…,A7,A0 on consecutive cycles, `out_sel` 0..7,0, no bubbles.
3. **Sparse requests:** only channels 2 and 5 valid, `out_ready=1` → alternating `out_sel` 2,5,2,5. `ptr` skips idle channels.
4. **Backpressure:** hold `out_ready=0` for 4 cycles with channel 3 valid, data 8'h5C → `out_valid=1` and `out_data=5C` stable, `in_ready=0` throughout. On release, 5C is consumed and the next grant goes to channel 3 again only if it is the sole requester.
5. **Wrap-around:** grant channel 7 with data 8'hF7, then channels 0 and 6 valid → next `out_sel=0`, then 6.
6. **Reset mid-operation:** `out_valid=1` holding 8'h33 with `out_ready=0`, assert `rst_n=0` for 1 cycle → `out_valid=0` and `ptr=0`, and the word is not delivered.
